// File: rtl/delay_mc.sv
// delay_mc: multichannel feedback delay (echo) sharing one synchronous RAM.
// Each channel owns a DEPTH-sample circular slice; a frame is processed one
// channel at a time through RD -> CALC -> WR.
// Optional macro DELAY_MC_CLEAR_EN: zero the whole buffer after reset release.
module delay_mc #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 48000,
    parameter int CHANNELS = 2
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         Enable,
    input  logic                         in_valid,
    input  logic [CHANNELS*WIDTH-1:0]    in,
    input  logic signed [WIDTH-1:0]      feedback,
    input  logic [31:0]                  looptime,
    output logic [CHANNELS*WIDTH-1:0]    out,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun
);

    localparam int TOTAL = CHANNELS * DEPTH;
    localparam int AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

`ifdef DELAY_MC_CLEAR_EN
    typedef enum logic [2:0] {IDLE, CLEAR, RD, CALC, WR} state_t;
    localparam state_t RESET_STATE = CLEAR;
    localparam logic   RESET_BUSY  = 1'b1;
`else
    typedef enum logic [2:0] {IDLE, RD, CALC, WR} state_t;
    localparam state_t RESET_STATE = IDLE;
    localparam logic   RESET_BUSY  = 1'b0;
`endif

    state_t                      state;
    logic [CHANNELS*WIDTH-1:0]   x_r;
    logic                        en_r;
    logic signed [WIDTH-1:0]     fb_r;
    logic [LW-1:0]               len_r;
    logic [LW-1:0]               len_eff;
    logic [CW-1:0]               ch;
    logic [PW-1:0]               ptr;
    logic signed [WIDTH-1:0]     w_r;
    logic signed [WIDTH-1:0]     w_next;
    logic signed [WIDTH-1:0]     x_cur;
    logic signed [2*WIDTH-1:0]   prod;
    logic signed [WIDTH+1:0]     scaled;
    logic signed [WIDTH+1:0]     sum;
`ifdef DELAY_MC_CLEAR_EN
    logic [AW-1:0]               clr_addr;
`endif

    logic [WIDTH-1:0]            mem [TOTAL];
    logic signed [WIDTH-1:0]     rdata;
    logic                        ram_we;
    logic                        ram_re;
    logic [AW-1:0]               ram_addr;
    logic [WIDTH-1:0]            ram_wdata;

    // Effective loop length: clamp looptime into 1..DEPTH
    always_comb begin
        len_eff = LW'(DEPTH);
        if (looptime == 32'd0)
            len_eff = LW'(1);
        else if (looptime < 32'(DEPTH))
            len_eff = LW'(looptime);
    end

    // Single RAM port: read in RD, write-back in WR, zero fill in CLEAR
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = AW'(ch) * AW'(DEPTH) + AW'(ptr);
        ram_wdata = w_r;
        case (state)
            RD:  ram_re = 1'b1;
            WR:  ram_we = 1'b1;
`ifdef DELAY_MC_CLEAR_EN
            CLEAR: begin
                ram_we    = 1'b1;
                ram_addr  = clr_addr;
                ram_wdata = '0;
            end
`endif
            default: ;
        endcase
    end

    // Sample buffer: synchronous read, contents never reset
    always_ff @(posedge Clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        else if (ram_re)
            rdata <= mem[ram_addr];
    end

    // Feedback arithmetic: x + (fb*d >>> (WIDTH-1)), saturated to WIDTH bits
    always_comb begin
        x_cur  = x_r[32'(ch)*WIDTH +: WIDTH];
        prod   = fb_r * rdata;
        scaled = (WIDTH+2)'(prod >>> (WIDTH-1));
        sum    = (WIDTH+2)'(x_cur) + scaled;
        if (sum[WIDTH+1:WIDTH-1] == '0 || sum[WIDTH+1:WIDTH-1] == '1)
            w_next = sum[WIDTH-1:0];
        else if (sum[WIDTH+1])
            w_next = {1'b1, {(WIDTH-1){1'b0}}};
        else
            w_next = {1'b0, {(WIDTH-1){1'b1}}};
    end

    // Control FSM with registered outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= RESET_STATE;
            busy      <= RESET_BUSY;
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            ptr       <= '0;
            ch        <= '0;
            x_r       <= '0;
            en_r      <= 1'b0;
            fb_r      <= '0;
            len_r     <= LW'(1);
            w_r       <= '0;
`ifdef DELAY_MC_CLEAR_EN
            clr_addr  <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            if (in_valid && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_r   <= in;
                        en_r  <= Enable;
                        fb_r  <= feedback;
                        len_r <= len_eff;
                        ch    <= '0;
                        if (32'(ptr) >= 32'(len_eff))
                            ptr <= '0;
                        busy  <= 1'b1;
                        state <= RD;
                    end
                end
                RD:   state <= CALC;
                CALC: begin
                    w_r   <= w_next;
                    state <= WR;
                end
                WR: begin
                    out[32'(ch)*WIDTH +: WIDTH] <= en_r ? w_r : x_cur;
                    if (ch != CW'(CHANNELS-1)) begin
                        ch    <= ch + CW'(1);
                        state <= RD;
                    end else begin
                        ptr       <= (32'(ptr) + 32'd1 == 32'(len_r)) ? '0 : ptr + PW'(1);
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
`ifdef DELAY_MC_CLEAR_EN
                CLEAR: begin
                    if (clr_addr == AW'(TOTAL-1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        clr_addr <= clr_addr + AW'(1);
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
